// File: rtl/dmem_responder.sv
// Single-outstanding, in-order data-memory responder with byte enables and programmable wait states.
// Accept at edge T: the response is registered on edge T+LATENCY+1 and held until rsp_ready.
module dmem_responder #(
  parameter int DEPTH   = 16,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_we
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_we_q, rsp_we_d;
  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      mem_d [DEPTH];

  logic             acc_err;
  logic [IDX_W-1:0] acc_idx;

  // Out-of-range indices are rejected rather than aliased onto low words.
  assign acc_err = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH));
  assign acc_idx = addr_q[IDX_W+1:2];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_we_d    = rsp_we_q;
    mem_d       = mem_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP: begin
        // First cycle in RESP performs the access; afterwards the response is held.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_we_d    = we_q;
          rsp_rdata_d = '0;
          rsp_err_d   = acc_err;
          if (!acc_err) begin
            if (we_q) begin
              for (int n = 0; n < 4; n++) begin
                if (be_q[n]) mem_d[acc_idx][8*n +: 8] = wdata_q[8*n +: 8];
              end
            end else begin
              rsp_rdata_d = mem_q[acc_idx];
            end
          end
        end else if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          rsp_we_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_we_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_we_q    <= rsp_we_d;
      mem_q       <= mem_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_we    = rsp_we_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed bench for dmem_responder (LATENCY=2 instance with a per-cycle
// reference model, plus a LATENCY=0 instance driven back-to-back).
module tb_dmem_responder;
  localparam int DEPTH = 16;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_we;
  logic [31:0] rsp_rdata;

  logic        z_req_valid, z_req_ready, z_req_we;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_be;
  logic        z_rsp_valid, z_rsp_err, z_rsp_we;
  logic        z_rsp_ready;
  logic [31:0] z_rsp_rdata;

  assign z_rsp_ready = 1'b1;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_we(rsp_we)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(0), .CNT_W(4)) dut_z (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
    .rsp_err(z_rsp_err), .rsp_we(z_rsp_we)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Reference model: memory as an array, the transaction as "busy for some cycles".
  logic [31:0] m_mem [DEPTH];
  bit          m_busy;
  int          m_age;
  int          n_acc = 0;
  logic [31:0] m_rdata;
  bit          m_err, m_we;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_busy = 0; m_age = 0; m_rdata = '0; m_err = 0; m_we = 0;
    end else if (m_busy) begin
      if (m_age >= LAT + 1 && rsp_ready) m_busy = 0;
      else m_age++;
    end else if (req_valid) begin
      m_busy = 1; m_age = 0; n_acc++;
      m_we = req_we;
      m_err = (req_addr % 4 != 0) || ((req_addr / 4) >= DEPTH);
      m_rdata = '0;
      if (!m_err) begin
        if (req_we) m_mem[req_addr / 4] = merge(m_mem[req_addr / 4], req_wdata, req_be);
        else        m_rdata = m_mem[req_addr / 4];
      end
    end
  end

  bit          chk_en = 0;
  logic [31:0] last_rdata;
  logic        last_err, last_we;

  always @(negedge clk) begin
    if (chk_en) begin
      bit ev;
      ev = m_busy && (m_age >= LAT + 1);
      chk("req_ready", {31'b0, req_ready}, {31'b0, !m_busy});
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, ev});
      chk("rsp_rdata", rsp_rdata, ev ? m_rdata : 32'h0);
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, ev ? m_err : 1'b0});
      chk("rsp_we", {31'b0, rsp_we}, {31'b0, ev ? m_we : 1'b0});
      if (ev) begin
        last_rdata = rsp_rdata; last_err = rsp_err; last_we = rsp_we;
      end
    end
  end

  task automatic wait_accept(input int a);
    int t;
    t = 0;
    while (n_acc == a && t < 100) begin @(negedge clk); t++; end
    if (n_acc == a) begin fails++; tests++; $display("FAIL accept_timeout: got none, expected accept"); end
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold,
                        output logic [31:0] rdata, output logic err, output logic wev, output int lat);
    int a, t;
    @(negedge clk);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    rsp_ready = (hold > 0) ? 1'b0 : 1'($urandom_range(0, 1));
    a = n_acc;
    wait_accept(a);
    req_valid = 0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      if (hold == 0) rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk); lat++;
    end
    if (hold > 0) begin
      // A competing request is presented while the response is being held off.
      req_valid = 1; req_we = 0; req_addr = 32'h0; req_be = 4'hF;
      repeat (hold) @(negedge clk);
      req_valid = 0;
      rsp_ready = 1;
      @(negedge clk);
      chk("bp_rsp_valid_drop", {31'b0, rsp_valid}, 32'h0);
      chk("bp_req_ready_back", {31'b0, req_ready}, 32'h1);
    end
    t = 0;
    while (m_busy && t < 100) begin
      rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk); t++;
    end
    if (m_busy) begin fails++; tests++; $display("FAIL rsp_timeout: got busy, expected idle"); end
    rsp_ready = 0;
    rdata = last_rdata; err = last_err; wev = last_we;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] rd;
    logic        er, wv;
    int          lat;
    logic [31:0] zm [DEPTH];
    logic [31:0] zexp;
    logic        s_we [5];
    logic [31:0] s_wd [5];
    logic [3:0]  s_be [5];

    reset = 1;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0; rsp_ready = 0;
    z_req_valid = 0; z_req_we = 0; z_req_addr = 0; z_req_wdata = 0; z_req_be = 0;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", {31'b0, req_ready}, 32'h1);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err", {31'b0, rsp_err}, 32'h0);
    @(posedge clk); #2 reset = 0; chk_en = 1;

    do_req(1, 32'h8, 32'hDEADBEEF, 4'hF, 0, rd, er, wv, lat);
    chk("st8_lat", lat, 32'd3);
    chk("st8_rdata", rd, 32'h0); chk("st8_err", {31'b0, er}, 32'h0); chk("st8_we", {31'b0, wv}, 32'h1);
    do_req(0, 32'h8, 32'h0, 4'h0, 0, rd, er, wv, lat);
    chk("ld8_lat", lat, 32'd3);
    chk("ld8_rdata", rd, 32'hDEADBEEF); chk("ld8_err", {31'b0, er}, 32'h0);

    do_req(1, 32'h4, 32'h11223344, 4'hF, 0, rd, er, wv, lat);
    do_req(1, 32'h4, 32'hAABBCCDD, 4'b0101, 0, rd, er, wv, lat);
    do_req(0, 32'h4, 32'h0, 4'hF, 0, rd, er, wv, lat);
    chk("be_merge", rd, 32'h11BB33DD);

    do_req(0, 32'h6, 32'h0, 4'hF, 0, rd, er, wv, lat);
    chk("misalign_err", {31'b0, er}, 32'h1); chk("misalign_rdata", rd, 32'h0);
    do_req(0, 32'h40, 32'h0, 4'hF, 0, rd, er, wv, lat);
    chk("oob_err", {31'b0, er}, 32'h1); chk("oob_rdata", rd, 32'h0);

    do_req(0, 32'h8, 32'h0, 4'hF, 5, rd, er, wv, lat);
    chk("bp_rdata", rd, 32'hDEADBEEF);

    // Reset in the middle of a pending store.
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = 32'hC; req_wdata = 32'h12345678; req_be = 4'hF;
    wait_accept(n_acc);
    req_valid = 0;
    @(posedge clk); #2 reset = 1;
    @(posedge clk); #2 reset = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", {31'b0, rsp_valid}, 32'h0);
    end
    do_req(0, 32'hC, 32'h0, 4'hF, 0, rd, er, wv, lat);
    chk("abort_ld_c", rd, 32'h0);

    do_req(1, 32'h41, 32'hFFFFFFFF, 4'hF, 0, rd, er, wv, lat);
    chk("st41_err", {31'b0, er}, 32'h1);
    for (int i = 0; i < DEPTH; i++) begin
      do_req(0, 32'(i * 4), 32'h0, 4'hF, 0, rd, er, wv, lat);
      chk("readback_zero", rd, 32'h0);
    end

    for (int k = 0; k < 300; k++) begin
      logic [31:0] ad;
      case ($urandom_range(0, 15))
        0:       ad = 32'hFFFFFFFC;
        1, 2:    ad = 32'($urandom_range(0, 80));
        default: ad = 32'($urandom_range(0, 19)) << 2;
      endcase
      do_req(1'($urandom_range(0, 1)), ad, $urandom, 4'($urandom_range(0, 15)),
             ($urandom_range(0, 7) == 0) ? 2 : 0, rd, er, wv, lat);
    end

    // LATENCY=0 instance: back-to-back requests with rsp_ready tied high.
    for (int i = 0; i < DEPTH; i++) zm[i] = '0;
    s_we[0] = 0; s_wd[0] = 32'h0;        s_be[0] = 4'hF;
    s_we[1] = 1; s_wd[1] = 32'hCAFEF00D; s_be[1] = 4'hF;
    s_we[2] = 0; s_wd[2] = 32'h0;        s_be[2] = 4'hF;
    s_we[3] = 1; s_wd[3] = 32'h0000AB00; s_be[3] = 4'b0010;
    s_we[4] = 0; s_wd[4] = 32'h0;        s_be[4] = 4'hF;
    zexp = '0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      z_req_valid = 1; z_req_we = s_we[i]; z_req_addr = 32'h10; z_req_wdata = s_wd[i]; z_req_be = s_be[i];
      chk("z_req_ready_idle", {31'b0, z_req_ready}, 32'h1);
      chk("z_rsp_valid_idle", {31'b0, z_rsp_valid}, 32'h0);
      zexp = '0;
      if (s_we[i]) zm[4] = merge(zm[4], s_wd[i], s_be[i]);
      else         zexp = zm[4];
      @(negedge clk);
      chk("z_req_ready_busy", {31'b0, z_req_ready}, 32'h0);
      chk("z_rsp_valid_early", {31'b0, z_rsp_valid}, 32'h0);
      if (i == 4) z_req_valid = 0;
      @(negedge clk);
      chk("z_rsp_valid", {31'b0, z_rsp_valid}, 32'h1);
      chk("z_rsp_rdata", z_rsp_rdata, zexp);
      chk("z_rsp_we", {31'b0, z_rsp_we}, {31'b0, s_we[i]});
      chk("z_rsp_err", {31'b0, z_rsp_err}, 32'h0);
      @(negedge clk);
    end
    chk("z_final_load", z_rsp_rdata | zexp, 32'hCAFEAB0D);
    chk("z_after_valid", {31'b0, z_rsp_valid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder serving load/store requests issued by the pipeline MEM stage over a valid/ready request channel. It returns one response per accepted request on a valid/ready response channel, after a programmable wait-state latency. It is a single-outstanding, in-order word-addressed memory with byte enables and error reporting. It stands in for the pipeline's flat data array, so the core can be run against realistic memory timing.

Parameters:
DEPTH, 16, number of 32-bit words; legal word indices 0..DEPTH-1
LATENCY, 2, wait cycles between acceptance and response (0..15)
CNT_W, 4, width of the wait counter; must hold LATENCY

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data
req_be  input  4  byte enables; bit n enables byte n (bits 8n+7:8n)
rsp_valid  output  1  response present
rsp_ready  input  1  consumer takes the response
rsp_rdata  output  32  load data; 0 for stores and errors
rsp_err  output  1  request was misaligned or out of range
rsp_we  output  1  echo of req_we for the accepted request

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- On reset:
  - state=IDLE
  - req_ready=1
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_we=0
  - wait counter=0
  - all DEPTH words of memory cleared to 0
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Handshake on req_valid & req_ready at a rising edge: latch we, addr, wdata and be.
  - If LATENCY=0, go to RESP. Otherwise load the counter with LATENCY-1 and go to WAIT.
- WAIT:
  - req_ready=0; decrement the counter each cycle.
  - When the counter is 0, go to RESP on the next edge.
- Entering RESP (a single edge) performs the access and registers the response outputs:
  - word index = latched addr[31:2].
  - Error: addr[1:0]!=0, or word index >= DEPTH. Then rsp_err=1, rsp_rdata=0, and no write occurs.
  - Store without error: each byte with be[n]=1 is written; other bytes are unchanged. rsp_rdata=0.
  - Load without error: rsp_rdata = memory word (be is ignored).
- RESP:
  - rsp_valid=1; rsp_rdata, rsp_err and rsp_we are held stable until rsp_ready=1.
  - On the rsp_valid & rsp_ready edge: go to IDLE, and clear rsp_valid, rsp_rdata, rsp_err and rsp_we to 0.
  - req_ready=0 throughout RESP. A new request is accepted no earlier than the cycle after the response handshake (no overlap).
- Latency: accept at edge T; rsp_valid is first high after edge T+LATENCY+1.
- Requests are processed strictly in order, one outstanding at a time.
- req_valid while req_ready=0 is ignored. The requester must hold it, with stable fields, until accepted.
- Read-after-write to the same word returns the new data (the write commits before the later read samples memory).
- Memory is writable only through the request channel.
- Reset asserted during WAIT or RESP:
  - Aborts immediately; the pending store is not committed.
  - Returns to IDLE with the reset values listed above.
- Address wrap: no wrap. Word index >= DEPTH is an error, never aliased (e.g. byte address 0x40 with DEPTH=16 is an error).

Test Plan:
- Store req_addr=0x8, wdata=0xDEADBEEF, be=0xF; then load 0x8 -> store response has rsp_err=0, rsp_rdata=0, rsp_we=1; load response has rsp_rdata=0xDEADBEEF, rsp_err=0. Each rsp_valid rises exactly LATENCY+1=3 cycles after acceptance.
- Word 0x4 holds 0x11223344; store wdata=0xAABBCCDD, be=0b0101; load 0x4 -> 0x11BB33DD.
- Load 0x6 (misaligned) and load 0x40 (index 16 >= DEPTH) -> both give rsp_err=1, rsp_rdata=0. A store to 0x41 -> rsp_err=1, and memory is unchanged (verified by full readback, all words 0).
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid rises -> rsp_valid and data stay stable, req_ready=0, and a second req_valid is not accepted. Raise rsp_ready -> next edge rsp_valid=0, and req_ready=1 the cycle after.
- Assert reset for 1 cycle during WAIT of a store of 0x12345678 to 0xC -> rsp_valid never rises. After reset, load 0xC -> 0.
- LATENCY=0 build: accept at edge T -> rsp_valid high after edge T+1. Back-to-back load/store/load sequence with rsp_ready tied to 1 gives correct data, one request accepted every 3 cycles.
